// File: rtl/apb_mst_pkg.sv
// Shared types for the APB master bridge: FSM states, command record, default FIFO depth.
// Latency: n/a (types only). Backpressure: n/a.
package apb_mst_pkg;

    localparam int CMD_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for the bridge; pready_i exists only with APB_MST_PREADY_EN.
// Latency: n/a. Backpressure: cmd valid/ready in, rsp valid/ready out.
interface apb_master_bridge_if;

    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_write_o;
    logic [31:0] rsp_rdata_o;

    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] prdata_i;
`ifdef APB_MST_PREADY_EN
    logic        pready_i;
`endif

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_write_o, rsp_rdata_o,
        input  rsp_ready_i,
        output paddr_o, pwdata_o, psel_o, penable_o, pwrite_o,
`ifdef APB_MST_PREADY_EN
        input  pready_i,
`endif
        input  prdata_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_write_o, rsp_rdata_o,
        output rsp_ready_i,
        input  paddr_o, pwdata_o, psel_o, penable_o, pwrite_o,
`ifdef APB_MST_PREADY_EN
        output pready_i,
`endif
        output prdata_i
    );

endinterface

// File: rtl/apb_mst_fifo.sv
// Synchronous FIFO of DEPTH (power of two, >= 2) entries of W bits; head is read combinationally.
// Latency: push visible at head the cycle after. Backpressure: push ignored when full, pop ignored when empty.
module apb_mst_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Queues local read/write commands and issues them as APB transfers; APB_MST_PREADY_EN adds pready_i wait states.
// Latency: 3 cycles push-to-response; backpressure: no new transfer starts while an unaccepted response is held.
module apb_master_bridge
    import apb_mst_pkg::*;
#(
    parameter int CMD_DEPTH = CMD_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_,
    apb_master_bridge_if.master  bus
);

    apb_state_e  r_state;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [31:0] r_rsp_rdata;

    apb_cmd_t    w_push_cmd;
    apb_cmd_t    w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_done;

    assign w_push_cmd.write = bus.cmd_write_i;
    assign w_push_cmd.addr  = bus.cmd_addr_i;
    assign w_push_cmd.wdata = bus.cmd_wdata_i;

    assign bus.cmd_ready_o = !w_full;
    assign w_push          = bus.cmd_valid_i && !w_full;
    assign w_pop           = (r_state == IDLE) && !w_empty && (!r_rsp_valid || bus.rsp_ready_i);

`ifdef APB_MST_PREADY_EN
    assign w_done = (r_state == ACCESS) && bus.pready_i;
`else
    assign w_done = (r_state == ACCESS);
`endif

    apb_mst_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     ($bits(apb_cmd_t))
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_    (rst_),
        .i_push  (w_push),
        .i_dat   (w_push_cmd),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // A completion wins over a same-cycle handshake so the new response is not lost.
            if (w_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_write <= r_pwrite;
                r_rsp_rdata <= r_pwrite ? 32'd0 : bus.prdata_i;
            end else if (r_rsp_valid && bus.rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_paddr   <= w_head.addr;
                        r_pwdata  <= w_head.wdata;
                        r_pwrite  <= w_head.write;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.psel_o      = r_psel;
    assign bus.penable_o   = r_penable;
    assign bus.pwrite_o    = r_pwrite;
    assign bus.paddr_o     = r_paddr;
    assign bus.pwdata_o    = r_pwdata;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_write_o = r_rsp_write;
    assign bus.rsp_rdata_o = r_rsp_rdata;

endmodule
